// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: FSM state encoding and the
// register-file funct codes that route requests to / results from this block.
package seq_divider_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor holds between steps, so WIDTH+1 bits suffice for the sign.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, divisor_i};
        qbit_o  = ~trial[WIDTH];
        rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider answering DIV/DIVU requests; quotient
// goes to LO, remainder to HI, qualified by a one-cycle done strobe.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dzp_q, dzp_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] a_mag, b_mag;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            araw_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dzp_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            araw_q  <= araw_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dzp_q   <= dzp_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (count_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        a_mag   = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag   = (signed_op && b[WIDTH-1]) ? -b : b;
        count_d = count_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        araw_d  = araw_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dzp_d   = dzp_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        if (state_q == S_IDLE && start) begin
            count_d = CW'(WIDTH);
            rem_d   = '0;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            araw_d  = a;
            negq_d  = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            negr_d  = signed_op & a[WIDTH-1];
            dzp_d   = (b == '0);
        end else if (state_q == S_RUN && count_q != '0) begin
            rem_d   = step_rem;
            dvd_d   = {dvd_q[WIDTH-2:0], step_qbit};
            count_d = count_q - CW'(1);
        end else if (state_q == S_RUN) begin
            // Divide by zero reports the raw dividend, skipping sign fixup.
            q_d  = dzp_q ? '1 : (negq_q ? -dvd_q : dvd_q);
            r_d  = dzp_q ? araw_q : (negr_q ? -rem_q : rem_q);
            dz_d = dzp_q;
        end
    end

    assign q       = q_q;
    assign r       = r_q;
    assign divzero = dz_q;

endmodule
